// File: rtl/pwm_cfg_sched.sv
// Double-buffered PWM configuration: host fills shadow registers, a validated commit copies them
// to the active set on the next timebase-zero cycle so a PWM period never mixes old and new settings.
module pwm_cfg_sched #(
    parameter int WIDTH  = 18,
    parameter int HRBITS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-HRBITS-1:0]  tb,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [2:0]               wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_commit,
    output logic [WIDTH-HRBITS-1:0]  prd,
    output logic [WIDTH-1:0]         cmp0H,
    output logic [WIDTH-1:0]         cmp0L,
    output logic [WIDTH-1:0]         cmp1H,
    output logic [WIDTH-1:0]         cmp1L,
    output logic                     pending,
    output logic                     done,
    output logic                     err
);

    localparam int PW = WIDTH - HRBITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   sh_prd;
    logic [WIDTH-1:0] sh_c0h, sh_c0l, sh_c1h, sh_c1l;

    // Shadow set as it will look after this beat's write; commit validation uses it.
    logic [PW-1:0]    nx_prd;
    logic [WIDTH-1:0] nx_c0h, nx_c0l, nx_c1h, nx_c1l;
    logic             accept;
    logic             addr_ok;
    logic             cfg_ok;

    assign accept  = wr_valid && wr_ready;
    assign addr_ok = (wr_addr <= 3'd4);

    always_comb begin
        nx_prd = sh_prd;
        nx_c0h = sh_c0h;
        nx_c0l = sh_c0l;
        nx_c1h = sh_c1h;
        nx_c1l = sh_c1l;
        if (accept) begin
            case (wr_addr)
                3'd0:    nx_prd = wr_data[PW-1:0];
                3'd1:    nx_c0h = wr_data;
                3'd2:    nx_c0l = wr_data;
                3'd3:    nx_c1h = wr_data;
                3'd4:    nx_c1l = wr_data;
                default: ;
            endcase
        end
        cfg_ok = (nx_c0h[WIDTH-1:HRBITS] <= nx_prd) &&
                 (nx_c0l[WIDTH-1:HRBITS] <= nx_prd) &&
                 (nx_c1h[WIDTH-1:HRBITS] <= nx_prd) &&
                 (nx_c1l[WIDTH-1:HRBITS] <= nx_prd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sh_prd   <= '1;
            sh_c0h   <= '0;
            sh_c0l   <= '0;
            sh_c1h   <= '0;
            sh_c1l   <= '0;
            prd      <= '1;
            cmp0H    <= '0;
            cmp0L    <= '0;
            cmp1H    <= '0;
            cmp1L    <= '0;
            wr_ready <= 1'b1;
            pending  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_valid) begin
                        sh_prd <= nx_prd;
                        sh_c0h <= nx_c0h;
                        sh_c0l <= nx_c0l;
                        sh_c1h <= nx_c1h;
                        sh_c1l <= nx_c1l;
                        if (!addr_ok)
                            err <= 1'b1;
                        if (wr_commit) begin
                            if (cfg_ok) begin
                                state    <= ARMED;
                                pending  <= 1'b1;
                                wr_ready <= 1'b0;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                ARMED: begin
                    // The core reloads tb from the old prd on this same edge.
                    if (tb == '0) begin
                        prd     <= sh_prd;
                        cmp0H   <= sh_c0h;
                        cmp0L   <= sh_c0l;
                        cmp1H   <= sh_c1h;
                        cmp1L   <= sh_c1l;
                        pending <= 1'b0;
                        done    <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    state    <= IDLE;
                    wr_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    wr_ready <= 1'b1;
                    pending  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pwm_cfg_sched.md
Name: pwm_cfg_sched

Overview:
- Double-buffered configuration scheduler for the two-channel high-resolution PWM core.
- A host writes period and compare values into shadow registers over a valid/ready port, then requests a commit.
- The block validates the shadow set and transfers it to the active outputs only at a PWM period boundary (timebase == 0), so a period never runs with mixed old/new settings.
- Active outputs drive the PWM core's prd and per-channel cmpH/cmpL inputs.

Parameters:
- WIDTH, 18, full compare width in bits (integer part plus HR fraction).
- HRBITS, 3, high-resolution fractional bits; timebase/period width is WIDTH-HRBITS.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- tb  in  WIDTH-HRBITS  PWM timebase (down-counter) from the PWM core.
- wr_valid  in  1  host write/commit request valid.
- wr_ready  out  1  block can accept a request this cycle.
- wr_addr  in  3  0=prd, 1=cmp0H, 2=cmp0L, 3=cmp1H, 4=cmp1L, 5..7 invalid.
- wr_data  in  WIDTH  write data; prd uses the low WIDTH-HRBITS bits, upper bits ignored.
- wr_commit  in  1  qualifies wr_valid: request a commit after any accompanying write.
- prd  out  WIDTH-HRBITS  active period.
- cmp0H, cmp0L, cmp1H, cmp1L  out  WIDTH each  active compare values.
- pending  out  1  commit armed, waiting for a period boundary.
- done  out  1  one-cycle pulse: active set updated.
- err  out  1  one-cycle pulse: invalid address or rejected commit.

Behaviour:
- Reset:
  - State IDLE.
  - Shadow and active prd = all ones; all shadow and active cmp = 0.
  - wr_ready=1, pending=0, done=0, err=0.
- Handshake:
  - A request is accepted when wr_valid & wr_ready at a rising edge.
  - wr_ready = 1 only in IDLE.
- IDLE:
  - Accepted write with valid addr: the shadow register updates at the edge.
  - Accepted write with addr 5..7: no shadow change; err=1 in the following cycle.
  - If wr_commit=1 on the same accepted beat, the write (if addr valid) lands in shadow first; validation then sees the updated value.
  - Commit validation is performed on the post-write shadow set. Each cmp integer part cmp[WIDTH-1:HRBITS] must be <= shadow prd.
  - Any violation: commit rejected, err pulse next cycle, state stays IDLE, shadow retained.
  - Pass: go to ARMED; pending=1 from the next cycle.
  - An invalid addr on a commit beat raises err, and the commit still proceeds if validation passes.
- ARMED:
  - wr_ready=0.
  - The first cycle with tb==0 triggers the transfer: active <= shadow at that edge, then go to HOLD.
  - If tb==0 in the first ARMED cycle, the transfer happens immediately; there is no minimum wait.
- HOLD:
  - One cycle; done=1, pending=0, wr_ready=0; then IDLE.
- Effect timing:
  - The core reloads tb from prd on the same edge the transfer occurs, using the old prd.
  - The new prd therefore governs the following period, while the new cmp values are seen from that reload onward.
- Outputs:
  - Active outputs change only on the transfer edge or reset.
  - Shadow values are never visible on the outputs.
- Reset mid-operation: rst in any state returns everything to reset values on that edge; a pending commit is discarded.
- Pulses: done and err are each exactly one cycle. They are never asserted together except when an invalid-addr commit beat is later followed by done.
- No arithmetic wrap: the comparison is unsigned, width WIDTH-HRBITS.

Test Plan:
- Reset, then idle for 10 cycles:
  - prd=all ones, all cmp=0, wr_ready=1, pending/done/err=0.
- Write prd=0x100, cmp0L=0x400, then a commit beat writing cmp1H=0x7F8, with tb held nonzero:
  - pending=1 and outputs unchanged.
  - Drive tb=0: next edge prd=0x100, cmp0L=0x400, cmp1H=0x7F8; done pulses one cycle; wr_ready returns the cycle after.
- Commit with shadow prd=0x10 and cmp0H=0x88 (integer part 0x11):
  - err pulse, no pending, active unchanged.
- Commit while tb==0 on the arming cycle:
  - Transfer on the first ARMED edge; done exactly 2 cycles after the accept edge.
- wr_valid held in ARMED/HOLD:
  - wr_ready=0, shadow unchanged.
  - Write to addr 6 in IDLE: err pulse, no register change.
- Assert rst while ARMED:
  - Outputs return to reset values, pending=0, and a subsequent tb==0 causes no transfer.
